// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase decoder: code width, FSM states
// and the legal-code table, where the array index is the phase.
package johnson_pkg;

   localparam int JC_W    = 4;
   localparam int PHASE_W = 3;
   localparam int N_PHASE = 8;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_TRACK    = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_FAULT    = 2'd3
   } jpd_state_e;

   localparam logic [JC_W-1:0] LEGAL_CODE [N_PHASE] = '{
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001
   };

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code lookup: flags legal codes and returns their phase.
module johnson_code_decode
   import johnson_pkg::*;
(
   input  logic [JC_W-1:0]    i_jc,
   output logic               o_legal,
   output logic [PHASE_W-1:0] o_phase
);

   always_comb begin
      o_legal = 1'b0;
      o_phase = '0;
      for (int i = 0; i < N_PHASE; i++) begin
         if (i_jc == LEGAL_CODE[i]) begin
            o_legal = 1'b1;
            o_phase = PHASE_W'(i);
         end
      end
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder with lock/fault tracking and wrap detection.
// Defining JPD_REV_COUNT_EN builds the revolution counter; otherwise rev_cnt is 0.
module johnson_phase_decoder
   import johnson_pkg::*;
#(
   parameter int LOCK_CNT = 3,
   parameter int REV_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [JC_W-1:0]    jc,
   input  logic               en,
   input  logic               clr,
   output logic [PHASE_W-1:0] phase,
   output logic [7:0]         phase_oh,
   output logic               phase_vld,
   output logic               locked,
   output logic               fault,
   output logic               wrap,
   output logic [REV_W-1:0]   rev_cnt
);

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

   jpd_state_e         r_state;
   jpd_state_e         w_state_nxt;
   logic [3:0]         r_good_cnt;
   logic [3:0]         w_good_cnt_nxt;
   logic [3:0]         w_good_inc;
   logic [PHASE_W-1:0] r_phase;
   logic [7:0]         r_phase_oh;
   logic               r_phase_vld;
   logic               r_locked;
   logic               r_fault;
   logic               r_wrap;

   logic               w_legal;
   logic [PHASE_W-1:0] w_dec_phase;
   logic [PHASE_W-1:0] w_phase_inc;
   logic               w_sample;
   logic               w_good;
   logic [PHASE_W-1:0] w_phase_nxt;
   logic               w_vld_nxt;
   logic [7:0]         w_oh_nxt;
   logic               w_wrap_nxt;

   johnson_code_decode u_decode (
      .i_jc    (jc),
      .o_legal (w_legal),
      .o_phase (w_dec_phase)
   );

   // The registered phase/valid pair doubles as the previous-sample history.
   assign w_sample    = en & ~clr;
   assign w_phase_inc = r_phase + 3'd1;
   assign w_good      = r_phase_vld & w_legal & (w_dec_phase == w_phase_inc);
   assign w_good_inc  = r_good_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state    <= ST_UNLOCKED;
         r_good_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_good_cnt_nxt = r_good_cnt;
      if (clr) begin
         w_state_nxt    = ST_UNLOCKED;
         w_good_cnt_nxt = '0;
      end else if (en) begin
         case (r_state)
            ST_UNLOCKED: begin
               if (w_legal) begin
                  w_state_nxt    = ST_TRACK;
                  w_good_cnt_nxt = '0;
               end
            end
            ST_TRACK: begin
               if (!w_good) begin
                  w_state_nxt    = ST_UNLOCKED;
                  w_good_cnt_nxt = '0;
               end else if (w_good_inc >= LOCK_TGT) begin
                  w_state_nxt    = ST_LOCKED;
                  w_good_cnt_nxt = '0;
               end else begin
                  w_good_cnt_nxt = w_good_inc;
               end
            end
            ST_LOCKED: begin
               if (!w_good) w_state_nxt = ST_FAULT;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_phase_nxt = (w_sample && w_legal) ? w_dec_phase : r_phase;
      w_vld_nxt   = w_sample ? w_legal : r_phase_vld;
      w_oh_nxt    = w_vld_nxt ? (8'b1 << w_phase_nxt) : 8'b0;
      w_wrap_nxt  = w_sample && (r_state == ST_LOCKED) && w_good
                    && (w_dec_phase == '0);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_phase     <= '0;
         r_phase_oh  <= '0;
         r_phase_vld <= 1'b0;
         r_locked    <= 1'b0;
         r_fault     <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_phase     <= w_phase_nxt;
         r_phase_oh  <= w_oh_nxt;
         r_phase_vld <= w_vld_nxt;
         r_locked    <= (w_state_nxt == ST_LOCKED);
         r_fault     <= (w_state_nxt == ST_FAULT);
         r_wrap      <= w_wrap_nxt;
      end
   end

`ifdef JPD_REV_COUNT_EN
   logic [REV_W-1:0] r_rev_cnt;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_rev_cnt <= '0;
      end else if (w_wrap_nxt) begin
         r_rev_cnt <= r_rev_cnt + 1'b1;
      end
   end

   assign rev_cnt = r_rev_cnt;
`else
   assign rev_cnt = '0;
`endif

   assign phase     = r_phase;
   assign phase_oh  = r_phase_oh;
   assign phase_vld = r_phase_vld;
   assign locked    = r_locked;
   assign fault     = r_fault;
   assign wrap      = r_wrap;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed scenarios plus a random walk,
// all checked against a behavioural model of the decoder's rules.
module tb_johnson_phase_decoder;

   localparam int LOCK = 3;
   localparam int REV  = 2;

   localparam int M_UNL = 0;
   localparam int M_TRK = 1;
   localparam int M_LCK = 2;
   localparam int M_FLT = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [3:0]     jc = 4'b0000;
   logic           en = 1'b0;
   logic           clr = 1'b0;
   logic [2:0]     phase;
   logic [7:0]     phase_oh;
   logic           phase_vld;
   logic           locked;
   logic           fault;
   logic           wrap;
   logic [REV-1:0] rev_cnt;

   logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};
   logic [3:0] bad_codes [8] = '{4'b0101, 4'b1010, 4'b0100, 4'b0010,
                                 4'b1001, 4'b0110, 4'b1011, 4'b1101};

   int n_chk = 0;
   int n_err = 0;

   int m_mode, m_good, m_phase, m_rev;
   bit m_vld, m_wrap;

   johnson_phase_decoder #(.LOCK_CNT(LOCK), .REV_W(REV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .jc        (jc),
      .en        (en),
      .clr       (clr),
      .phase     (phase),
      .phase_oh  (phase_oh),
      .phase_vld (phase_vld),
      .locked    (locked),
      .fault     (fault),
      .wrap      (wrap),
      .rev_cnt   (rev_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rev_exp(input int k);
`ifdef JPD_REV_COUNT_EN
      return k % (1 << REV);
`else
      return 0;
`endif
   endfunction

   // Rules-level model: lookup by table search, transition by phase arithmetic.
   task automatic model_step(input bit r, input bit e, input bit c, input logic [3:0] j);
      int  ph;
      bit  lg, good;
      m_wrap = 1'b0;
      if (r) begin
         m_mode = M_UNL; m_good = 0; m_phase = 0; m_vld = 0; m_rev = 0;
         return;
      end
      if (c) begin
         m_mode = M_UNL; m_good = 0;
         return;
      end
      if (!e) return;
      lg = 0; ph = 0;
      for (int i = 0; i < 8; i++) if (codes[i] == j) begin lg = 1; ph = i; end
      good = m_vld && lg && (ph == (m_phase + 1) % 8);
      case (m_mode)
         M_UNL: if (lg) begin m_mode = M_TRK; m_good = 0; end
         M_TRK: begin
            if (!good) begin m_mode = M_UNL; m_good = 0; end
            else begin
               m_good++;
               if (m_good >= LOCK) begin m_mode = M_LCK; m_good = 0; end
            end
         end
         M_LCK: begin
            if (good && ph == 0) m_wrap = 1'b1;
            if (!good) m_mode = M_FLT;
         end
         default: ;
      endcase
      if (lg) begin m_phase = ph; m_vld = 1; end
      else m_vld = 0;
      if (m_wrap) m_rev = rev_exp(m_rev + 1);
   endtask

   task automatic step(input bit r, input bit e, input bit c, input logic [3:0] j);
      @(negedge clk);
      rst_n = r; en = e; clr = c; jc = j;
      @(posedge clk);
      model_step(r, e, c, j);
      #1;
      chk("phase", 32'(phase), 32'(m_phase));
      chk("phase_oh", 32'(phase_oh), m_vld ? (32'd1 << m_phase) : 32'd0);
      chk("phase_vld", 32'(phase_vld), 32'(m_vld));
      chk("locked", 32'(locked), 32'(m_mode == M_LCK));
      chk("fault", 32'(fault), 32'(m_mode == M_FLT));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("rev_cnt", 32'(rev_cnt), 32'(m_rev));
   endtask

   initial begin
      int nw;
      int k;
      int nxt;
      logic [3:0] j;

      m_mode = M_UNL; m_good = 0; m_phase = 0; m_vld = 0; m_rev = 0; m_wrap = 0;

      // reset state
      step(1, 0, 0, 4'b0000);
      chk("rst_all", {26'd0, locked, fault, wrap, phase_vld, phase}, 32'd0);
      chk("rst_oh", 32'(phase_oh), 32'd0);

      // lock on the first four upstream codes
      for (int i = 0; i < 4; i++) step(0, 1, 0, codes[i]);
      chk("lock4_locked", 32'(locked), 32'd1);
      chk("lock4_phase", 32'(phase), 32'd3);
      chk("lock4_oh", 32'(phase_oh), 32'h08);

      // two revolutions
      nw = 0;
      for (int i = 4; i <= 16; i++) begin
         step(0, 1, 0, codes[i % 8]);
         if (wrap) begin
            nw++;
            chk("wrap_on_0000", 32'(jc), 32'd0);
         end
      end
      chk("two_wraps", 32'(nw), 32'd2);
      chk("rev_after_2", 32'(rev_cnt), 32'(rev_exp(2)));

      // illegal code while locked, then clear
      step(0, 1, 0, 4'b0101);
      chk("inj_fault", 32'(fault), 32'd1);
      chk("inj_locked", 32'(locked), 32'd0);
      chk("inj_vld", 32'(phase_vld), 32'd0);
      step(0, 1, 0, 4'b1000);
      step(0, 1, 0, 4'b1100);
      chk("fault_sticky", 32'(fault), 32'd1);
      step(0, 0, 1, 4'b1110);
      chk("clr_fault", 32'(fault), 32'd0);
      chk("clr_locked", 32'(locked), 32'd0);

      // repeated code in TRACK drops back, then relock
      step(1, 0, 0, 4'b0000);
      step(0, 1, 0, 4'b0000);
      step(0, 1, 0, 4'b1000);
      step(0, 1, 0, 4'b1100);
      step(0, 1, 0, 4'b1100);
      chk("repeat_unlocked", 32'(locked), 32'd0);
      step(0, 1, 0, 4'b1110);
      step(0, 1, 0, 4'b1111);
      step(0, 1, 0, 4'b0111);
      chk("relock_pending", 32'(locked), 32'd0);
      step(0, 1, 0, 4'b0011);
      chk("relock_locked", 32'(locked), 32'd1);

      // en low while jc wanders
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 4'($urandom_range(15)));
         chk("hold_phase", 32'(phase), 32'd6);
         chk("hold_locked", 32'(locked), 32'd1);
      end
      step(0, 1, 0, 4'b0001);
      chk("resume_locked", 32'(locked), 32'd1);
      chk("resume_fault", 32'(fault), 32'd0);

      // rev_cnt rollover over four revolutions, then reset mid-lock
      step(1, 0, 0, 4'b0000);
      for (int i = 0; i < 4; i++) step(0, 1, 0, codes[i]);
      nw = 0;
      for (int i = 4; i < 36; i++) begin
         step(0, 1, 0, codes[i % 8]);
         if (wrap) begin
            nw++;
            chk("rev_roll", 32'(rev_cnt), 32'(rev_exp(nw)));
         end
      end
      chk("four_wraps", 32'(nw), 32'd4);
      step(1, 1, 1, 4'b0111);
      chk("midrst_all", {26'd0, locked, fault, wrap, phase_vld, phase}, 32'd0);
      chk("midrst_rev", 32'(rev_cnt), 32'd0);

      // random walk
      for (int i = 0; i < 600; i++) begin
         k = $urandom_range(99);
         nxt = (m_phase + 1) % 8;
         if (k < 70)      j = codes[nxt];
         else if (k < 78) j = codes[m_phase];
         else if (k < 88) j = codes[$urandom_range(7)];
         else             j = bad_codes[$urandom_range(7)];
         step(($urandom_range(199) == 0), ($urandom_range(99) < 85),
              ($urandom_range(39) == 0), j);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
